// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. The fetch PC is looked up combinationally; resolved branches
// train the table at the next rising edge. Lookup and mispredict statistics
// are kept in saturating counters.
module branch_predictor #(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 4,
    parameter int CTR_W  = 2,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lk_pc,
    input  logic              lk_valid,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [ADDR_W-1:0] lk_target,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_mispred,
    input  logic              flush,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W;

    // Counter encodings: weakly-taken has only the MSB set, weakly-not-taken
    // has every bit except the MSB set.
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_MIN = '0;
    localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};

    logic              valid_q  [DEPTH];
    logic [TAG_W-1:0]  tag_q    [DEPTH];
    logic [ADDR_W-1:0] target_q [DEPTH];
    logic [CTR_W-1:0]  ctr_q    [DEPTH];

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;
    logic              upd_write;

    assign lk_idx  = lk_pc[IDX_W-1:0];
    assign lk_tag  = lk_pc[ADDR_W-1:IDX_W];
    assign upd_idx = upd_pc[IDX_W-1:0];
    assign upd_tag = upd_pc[ADDR_W-1:IDX_W];

    // Lookup sees the table contents as of the last edge, so an update in
    // flight this cycle is not yet visible.
    assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken  = lk_hit && ctr_q[lk_idx][CTR_W-1];
    assign lk_target = lk_taken ? target_q[lk_idx] : lk_pc + ADDR_W'(1);

    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    // Only taken updates touch tag/target; reset and flush discard the update.
    assign upd_write = !rst && !flush && upd_en && upd_taken;

    // Valid bits and direction counters: reset, flush and training.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, whatever the statement order.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (upd_en) begin
            if (upd_taken) begin
                if (upd_hit) begin
                    if (ctr_q[upd_idx] != CTR_MAX) begin
                        ctr_q[upd_idx] <= ctr_q[upd_idx] + CTR_W'(1);
                    end
                end else begin
                    valid_q[upd_idx] <= 1'b1;
                    ctr_q[upd_idx]   <= CTR_WT;
                end
            end else if (upd_hit && (ctr_q[upd_idx] != CTR_MIN)) begin
                ctr_q[upd_idx] <= ctr_q[upd_idx] - CTR_W'(1);
            end
        end
    end

    // Tag and target storage, written on every accepted taken update.
    always_ff @(posedge clk) begin
        // NOTE: tags and targets are deliberately left out of reset; the
        // cleared valid bit already hides them, and an unreset array maps
        // onto plain RAM.
        if (upd_write) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
        end
    end

    // Saturating statistics; flush leaves them alone, reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups <= '0;
            stat_mispred <= '0;
        end else begin
            if (lk_valid && (stat_lookups != '1)) begin
                stat_lookups <= stat_lookups + STAT_W'(1);
            end
            if (upd_en && upd_mispred && (stat_mispred != '1)) begin
                stat_mispred <= stat_mispred + STAT_W'(1);
            end
        end
    end

endmodule
